// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the request/response buses that pass through the data-memory
// arbiter:
//   port 0 (CPU)    : p0_addr, p0_write_data, p0_memwrite, p0_memread,
//                     p0_sign_mask -> p0_read_data, p0_stall, p0_done
//   port 1 (debug)  : p1_addr, p1_write_data, p1_memwrite, p1_memread,
//                     p1_sign_mask -> p1_read_data, p1_done, p1_err
//   memory side     : mem_addr, mem_write_data, mem_memwrite, mem_memread,
//                     mem_sign_mask <- mem_read_data, mem_clk_stall
//   status          : timeout_err (sticky)
// Modport slave is the arbiter's view; modport master is the view of the
// surrounding environment (requesters plus memory).
// ---------------------------------------------------------------------------
interface dmem_arbiter_if;
    logic [31:0] p0_addr;
    logic [31:0] p0_write_data;
    logic        p0_memwrite;
    logic        p0_memread;
    logic [3:0]  p0_sign_mask;
    logic [31:0] p0_read_data;
    logic        p0_stall;
    logic        p0_done;

    logic [31:0] p1_addr;
    logic [31:0] p1_write_data;
    logic        p1_memwrite;
    logic        p1_memread;
    logic [3:0]  p1_sign_mask;
    logic [31:0] p1_read_data;
    logic        p1_done;
    logic        p1_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data;
    logic        mem_clk_stall;

    logic        timeout_err;

    modport slave (
        input  p0_addr, p0_write_data, p0_memwrite, p0_memread, p0_sign_mask,
        output p0_read_data, p0_stall, p0_done,
        input  p1_addr, p1_write_data, p1_memwrite, p1_memread, p1_sign_mask,
        output p1_read_data, p1_done, p1_err,
        output mem_addr, mem_write_data, mem_memwrite, mem_memread, mem_sign_mask,
        input  mem_read_data, mem_clk_stall,
        output timeout_err
    );

    modport master (
        output p0_addr, p0_write_data, p0_memwrite, p0_memread, p0_sign_mask,
        input  p0_read_data, p0_stall, p0_done,
        output p1_addr, p1_write_data, p1_memwrite, p1_memread, p1_sign_mask,
        input  p1_read_data, p1_done, p1_err,
        input  mem_addr, mem_write_data, mem_memwrite, mem_memread, mem_sign_mask,
        output mem_read_data, mem_clk_stall,
        input  timeout_err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares one data memory between the CPU load/store port (port 0) and a
// debug/DMA master (port 1). Round-robin between simultaneous requesters,
// a one-cycle idle gap between transactions (the memory only starts work
// when its inputs change), and a watchdog that aborts an access if the
// memory never raises mem_clk_stall.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high
//   bus   - dmem_arbiter_if.slave (both requester ports, memory side,
//           sticky timeout_err)
// Parameters:
//   TIMEOUT - ISSUE cycles allowed before the access is aborted
//   CNT_W   - timeout counter width, 2**CNT_W must exceed TIMEOUT
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        BUSY  = 3'd2,
        DONE  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;       // port currently being served
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_write_data_q, mem_write_data_d;
    logic              mem_memwrite_q, mem_memwrite_d;
    logic              mem_memread_q, mem_memread_d;
    logic [3:0]        mem_sign_mask_q, mem_sign_mask_d;

    logic [31:0]       p0_read_data_q, p0_read_data_d;
    logic [31:0]       p1_read_data_q, p1_read_data_d;
    logic              p0_done_q, p0_done_d;
    logic              p1_done_q, p1_done_d;
    logic              p1_err_q, p1_err_d;
    logic              timeout_err_q, timeout_err_d;

    logic              req0_s, req1_s, winner_s;

    assign req0_s = bus.p0_memread | bus.p0_memwrite;
    assign req1_s = bus.p1_memread | bus.p1_memwrite;
    // Sole requester wins; on a tie the port that did not win last time goes.
    assign winner_s = (req0_s & req1_s) ? ~last_grant_q : req1_s;

    // Next-state, grant capture and completion logic.
    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        grant_d          = grant_q;
        cnt_d            = cnt_q;
        mem_addr_d       = mem_addr_q;
        mem_write_data_d = mem_write_data_q;
        mem_memwrite_d   = mem_memwrite_q;
        mem_memread_d    = mem_memread_q;
        mem_sign_mask_d  = mem_sign_mask_q;
        p0_read_data_d   = p0_read_data_q;
        p1_read_data_d   = p1_read_data_q;
        p0_done_d        = 1'b0;
        p1_done_d        = 1'b0;
        p1_err_d         = p1_err_q;
        timeout_err_d    = timeout_err_q;

        case (state_q)
            IDLE: begin
                mem_memread_d  = 1'b0;
                mem_memwrite_d = 1'b0;
                if (req0_s | req1_s) begin
                    grant_d      = winner_s;
                    last_grant_d = winner_s;
                    cnt_d        = '0;
                    state_d      = ISSUE;
                    // Read+write together is served as a write.
                    if (winner_s) begin
                        mem_addr_d       = bus.p1_addr;
                        mem_write_data_d = bus.p1_write_data;
                        mem_sign_mask_d  = bus.p1_sign_mask;
                        mem_memwrite_d   = bus.p1_memwrite;
                        mem_memread_d    = bus.p1_memread & ~bus.p1_memwrite;
                    end else begin
                        mem_addr_d       = bus.p0_addr;
                        mem_write_data_d = bus.p0_write_data;
                        mem_sign_mask_d  = bus.p0_sign_mask;
                        mem_memwrite_d   = bus.p0_memwrite;
                        mem_memread_d    = bus.p0_memread & ~bus.p0_memwrite;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            ISSUE: begin
                cnt_d = cnt_q + CNT_ONE;
                if (bus.mem_clk_stall) begin
                    state_d = BUSY;
                end else if (cnt_d == TIMEOUT_C) begin
                    // Memory never acknowledged: abort with zero data.
                    state_d        = DONE;
                    mem_memread_d  = 1'b0;
                    mem_memwrite_d = 1'b0;
                    timeout_err_d  = 1'b1;
                    if (grant_q) begin
                        p1_done_d      = 1'b1;
                        p1_read_data_d = 32'h0000_0000;
                        p1_err_d       = 1'b1;
                    end else begin
                        p0_done_d      = 1'b1;
                        p0_read_data_d = 32'h0000_0000;
                    end
                end else begin
                    state_d = ISSUE;
                end
            end

            BUSY: begin
                if (!bus.mem_clk_stall) begin
                    state_d        = DONE;
                    mem_memread_d  = 1'b0;
                    mem_memwrite_d = 1'b0;
                    if (grant_q) begin
                        p1_done_d      = 1'b1;
                        p1_read_data_d = mem_memwrite_q ? 32'h0000_0000 : bus.mem_read_data;
                        p1_err_d       = 1'b0;
                    end else begin
                        p0_done_d      = 1'b1;
                        p0_read_data_d = mem_memwrite_q ? 32'h0000_0000 : bus.mem_read_data;
                    end
                end else begin
                    state_d = BUSY;
                end
            end

            // Done outputs are already registered; this cycle only ends the access.
            DONE: begin
                state_d = GAP;
            end

            // Idle cycle so the memory sees an input change before the next access.
            GAP: begin
                state_d = IDLE;
            end

            default: begin
                state_d        = IDLE;
                mem_memread_d  = 1'b0;
                mem_memwrite_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            last_grant_q     <= 1'b1;
            grant_q          <= 1'b0;
            cnt_q            <= '0;
            mem_addr_q       <= 32'h0000_0000;
            mem_write_data_q <= 32'h0000_0000;
            mem_memwrite_q   <= 1'b0;
            mem_memread_q    <= 1'b0;
            mem_sign_mask_q  <= 4'h0;
            p0_read_data_q   <= 32'h0000_0000;
            p1_read_data_q   <= 32'h0000_0000;
            p0_done_q        <= 1'b0;
            p1_done_q        <= 1'b0;
            p1_err_q         <= 1'b0;
            timeout_err_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            grant_q          <= grant_d;
            cnt_q            <= cnt_d;
            mem_addr_q       <= mem_addr_d;
            mem_write_data_q <= mem_write_data_d;
            mem_memwrite_q   <= mem_memwrite_d;
            mem_memread_q    <= mem_memread_d;
            mem_sign_mask_q  <= mem_sign_mask_d;
            p0_read_data_q   <= p0_read_data_d;
            p1_read_data_q   <= p1_read_data_d;
            p0_done_q        <= p0_done_d;
            p1_done_q        <= p1_done_d;
            p1_err_q         <= p1_err_d;
            timeout_err_q    <= timeout_err_d;
        end
    end

    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_write_data = mem_write_data_q;
    assign bus.mem_memwrite   = mem_memwrite_q;
    assign bus.mem_memread    = mem_memread_q;
    assign bus.mem_sign_mask  = mem_sign_mask_q;
    assign bus.p0_read_data   = p0_read_data_q;
    assign bus.p1_read_data   = p1_read_data_q;
    assign bus.p0_done        = p0_done_q;
    assign bus.p1_done        = p1_done_q;
    assign bus.p1_err         = p1_err_q;
    assign bus.timeout_err    = timeout_err_q;
    // The CPU is released combinationally in its own done cycle.
    assign bus.p0_stall       = req0_s & ~p0_done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter: a table of single-transaction
// vectors plus hand-written sequences for back-to-back stores, round-robin
// under contention and reset during BUSY. A small memory model raises
// mem_clk_stall for two cycles, starting the cycle after a new request
// appears on the mem_* bus.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model state.
    logic        stall_en = 1'b1;
    logic        mem_stall_r = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [69:0] mem_prev = '0;
    logic [69:0] mem_cur;
    int          stall_cnt = 0;

    assign bus.mem_clk_stall = mem_stall_r;
    assign bus.mem_read_data = mem_rdata;
    assign mem_cur = {bus.mem_addr, bus.mem_write_data, bus.mem_memwrite,
                      bus.mem_memread, bus.mem_sign_mask};

    // Memory busy model: new request -> stall high for the next two cycles.
    always @(posedge clk) begin
        mem_prev <= mem_cur;
        if ((mem_cur != mem_prev) && (bus.mem_memwrite || bus.mem_memread)) begin
            stall_cnt   <= 2;
            mem_stall_r <= stall_en;
        end else if (stall_cnt > 0) begin
            stall_cnt   <= stall_cnt - 1;
            mem_stall_r <= stall_en && (stall_cnt > 1);
        end else begin
            mem_stall_r <= 1'b0;
        end
    end

    typedef struct {
        logic        port;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        stall_en;
        logic [31:0] mem_rdata;
        logic        exp_mem_rd;
        logic        exp_mem_wr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    logic [31:0] exp_p0_hold = 32'h0;
    logic [31:0] exp_p1_hold = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drop_requests();
        bus.p0_memread  = 1'b0;
        bus.p0_memwrite = 1'b0;
        bus.p1_memread  = 1'b0;
        bus.p1_memwrite = 1'b0;
    endtask

    // One isolated transaction; called at a negedge with the arbiter idle.
    task automatic run_vec(input vec_t v, input int idx);
        int   n;
        logic seen;
        stall_en  = v.stall_en;
        mem_rdata = v.mem_rdata;
        if (v.port == 1'b0) begin
            bus.p0_addr = v.addr; bus.p0_write_data = v.wdata; bus.p0_sign_mask = v.mask;
            bus.p0_memread = v.rd; bus.p0_memwrite = v.wr;
        end else begin
            bus.p1_addr = v.addr; bus.p1_write_data = v.wdata; bus.p1_sign_mask = v.mask;
            bus.p1_memread = v.rd; bus.p1_memwrite = v.wr;
        end
        #1;
        if (v.port == 1'b0) chk($sformatf("v%0d_p0_stall_req", idx), {31'd0, bus.p0_stall}, 32'd1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk($sformatf("v%0d_mem_addr", idx), bus.mem_addr, v.addr);
                chk($sformatf("v%0d_mem_wdata", idx), bus.mem_write_data, v.wdata);
                chk($sformatf("v%0d_mem_mask", idx), {28'd0, bus.mem_sign_mask}, {28'd0, v.mask});
                chk($sformatf("v%0d_mem_memread", idx), {31'd0, bus.mem_memread}, {31'd0, v.exp_mem_rd});
                chk($sformatf("v%0d_mem_memwrite", idx), {31'd0, bus.mem_memwrite}, {31'd0, v.exp_mem_wr});
            end
            if (v.port ? bus.p1_done : bus.p0_done) seen = 1'b1;
        end
        chk($sformatf("v%0d_done_seen", idx), {31'd0, seen}, 32'd1);
        chk($sformatf("v%0d_latency", idx), n, v.exp_lat);
        chk($sformatf("v%0d_done_mem_rd", idx), {31'd0, bus.mem_memread}, 32'd0);
        chk($sformatf("v%0d_done_mem_wr", idx), {31'd0, bus.mem_memwrite}, 32'd0);
        chk($sformatf("v%0d_timeout_err", idx), {31'd0, bus.timeout_err}, {31'd0, v.exp_err});
        if (v.port == 1'b0) begin
            chk($sformatf("v%0d_p0_read_data", idx), bus.p0_read_data, v.exp_rdata);
            chk($sformatf("v%0d_p1_read_hold", idx), bus.p1_read_data, exp_p1_hold);
            chk($sformatf("v%0d_p0_stall_done", idx), {31'd0, bus.p0_stall}, 32'd0);
            chk($sformatf("v%0d_p1_done_quiet", idx), {31'd0, bus.p1_done}, 32'd0);
            exp_p0_hold = v.exp_rdata;
        end else begin
            chk($sformatf("v%0d_p1_read_data", idx), bus.p1_read_data, v.exp_rdata);
            chk($sformatf("v%0d_p1_err", idx), {31'd0, bus.p1_err}, {31'd0, v.exp_err});
            chk($sformatf("v%0d_p0_read_hold", idx), bus.p0_read_data, exp_p0_hold);
            chk($sformatf("v%0d_p0_done_quiet", idx), {31'd0, bus.p0_done}, 32'd0);
            exp_p1_hold = v.exp_rdata;
        end
        drop_requests();
        @(negedge clk);
        @(negedge clk);
    endtask

    // Global time bound.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Main stimulus.
    initial begin
        int   dones, rises, low_run, k;
        int   done_at [4];
        int   order [4];
        logic prev_w;

        //            port  rd    wr    addr          wdata         mask   st_en mem_rdata     e_rd  e_wr  e_rdata       e_err lat
        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h0000_1008, 32'h0000_0055, 4'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 5};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0000_100C, 32'hCAFE_0001, 4'h1, 1'b1, 32'h1111_2222, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 5};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_1004, 32'h0000_0000, 4'h2, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 5};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_0000, 4'h4, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 5};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h0000_2004, 32'h0BAD_F00D, 4'h3, 1'b1, 32'h9999_9999, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 5};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_2008, 32'h0000_0000, 4'h0, 1'b0, 32'h8765_4321, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 17};

        reset = 1'b1;
        bus.p0_addr = 32'h0; bus.p0_write_data = 32'h0; bus.p0_sign_mask = 4'h0;
        bus.p1_addr = 32'h0; bus.p1_write_data = 32'h0; bus.p1_sign_mask = 4'h0;
        drop_requests();
        @(negedge clk);
        @(negedge clk);

        // Reset state.
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_write_data, 32'h0);
        chk("rst_mem_memwrite", {31'd0, bus.mem_memwrite}, 32'd0);
        chk("rst_mem_memread", {31'd0, bus.mem_memread}, 32'd0);
        chk("rst_mem_mask", {28'd0, bus.mem_sign_mask}, 32'd0);
        chk("rst_p0_read_data", bus.p0_read_data, 32'h0);
        chk("rst_p1_read_data", bus.p1_read_data, 32'h0);
        chk("rst_p0_done", {31'd0, bus.p0_done}, 32'd0);
        chk("rst_p1_done", {31'd0, bus.p1_done}, 32'd0);
        chk("rst_p1_err", {31'd0, bus.p1_err}, 32'd0);
        chk("rst_timeout_err", {31'd0, bus.timeout_err}, 32'd0);
        chk("rst_p0_stall", {31'd0, bus.p0_stall}, 32'd0);
        reset = 1'b0;

        // Table of isolated transactions.
        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        @(negedge clk);
        chk("timeout_err_sticky_1", {31'd0, bus.timeout_err}, 32'd1);

        // Back-to-back identical stores with the request held throughout.
        stall_en = 1'b1;
        mem_rdata = 32'h0;
        bus.p0_addr = 32'h0000_1008; bus.p0_write_data = 32'h0000_0055; bus.p0_sign_mask = 4'h0;
        bus.p0_memwrite = 1'b1; bus.p0_memread = 1'b0;
        dones = 0; rises = 0; low_run = 0;
        done_at[0] = 0; done_at[1] = 0;
        prev_w = bus.mem_memwrite;
        for (int n = 1; n <= 30 && dones < 2; n++) begin
            @(negedge clk);
            if (bus.mem_memwrite && !prev_w) rises++;
            if (rises == 1 && !bus.mem_memwrite) low_run++;
            if (bus.p0_done) begin
                done_at[dones] = n;
                dones++;
            end
            prev_w = bus.mem_memwrite;
        end
        drop_requests();
        chk("b2b_done_count", dones, 32'd2);
        chk("b2b_mem_transactions", rises, 32'd2);
        chk("b2b_write_low_gap", low_run, 32'd3);
        chk("b2b_first_done", done_at[0], 32'd5);
        chk("b2b_second_done", done_at[1], 32'd12);
        @(negedge clk);
        @(negedge clk);
        chk("timeout_err_sticky_2", {31'd0, bus.timeout_err}, 32'd1);

        // Reset during BUSY: everything cleared, no done pulse afterwards.
        mem_rdata = 32'h0000_0077;
        bus.p0_addr = 32'h0000_3000; bus.p0_sign_mask = 4'h2;
        bus.p0_memread = 1'b1; bus.p0_memwrite = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("busy_mem_memread", {31'd0, bus.mem_memread}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rbusy_mem_addr", bus.mem_addr, 32'h0);
        chk("rbusy_mem_memread", {31'd0, bus.mem_memread}, 32'd0);
        chk("rbusy_mem_memwrite", {31'd0, bus.mem_memwrite}, 32'd0);
        chk("rbusy_mem_mask", {28'd0, bus.mem_sign_mask}, 32'd0);
        chk("rbusy_p0_done", {31'd0, bus.p0_done}, 32'd0);
        chk("rbusy_p0_read_data", bus.p0_read_data, 32'h0);
        chk("rbusy_timeout_err", {31'd0, bus.timeout_err}, 32'd0);
        reset = 1'b0;
        drop_requests();
        exp_p0_hold = 32'h0;
        exp_p1_hold = 32'h0;
        dones = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus.p0_done || bus.p1_done) dones++;
        end
        chk("rbusy_no_done", dones, 32'd0);
        run_vec(vecs[2], 100);

        // Both ports requesting continuously from reset: strict alternation.
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        stall_en = 1'b1;
        mem_rdata = 32'hA5A5_0001;
        bus.p0_addr = 32'h0000_0100; bus.p0_sign_mask = 4'h0;
        bus.p1_addr = 32'h0000_0200; bus.p1_sign_mask = 4'h0;
        bus.p0_memread = 1'b1; bus.p0_memwrite = 1'b0;
        bus.p1_memread = 1'b1; bus.p1_memwrite = 1'b0;
        k = 0;
        for (int n = 1; n <= 60 && k < 4; n++) begin
            @(negedge clk);
            if (bus.p0_done) begin
                order[k] = 0; done_at[k] = n; k++;
                chk("rr_p0_stall_at_done", {31'd0, bus.p0_stall}, 32'd0);
                chk("rr_p0_read_data", bus.p0_read_data, 32'hA5A5_0001);
            end else if (bus.p1_done) begin
                order[k] = 1; done_at[k] = n; k++;
                chk("rr_p0_stall_during_p1", {31'd0, bus.p0_stall}, 32'd1);
                chk("rr_p1_read_data", bus.p1_read_data, 32'hA5A5_0001);
            end else begin
                if (n == 8) chk("rr_p0_stall_waiting", {31'd0, bus.p0_stall}, 32'd1);
            end
        end
        drop_requests();
        chk("rr_completions", k, 32'd4);
        for (int j = 0; j < 4; j++) begin
            if (j < k) begin
                chk($sformatf("rr_order_%0d", j), order[j], j % 2);
                chk($sformatf("rr_done_cycle_%0d", j), done_at[j], 5 + 7 * j);
            end
        end
        @(negedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
